// File: rtl/barrett_issue_if.sv
// Handshake and datapath bundle between the job source, the barrett divider
// and the result consumer around barrett_issue_ctrl.
interface barrett_issue_if #(
  parameter int M0LEN = 14,
  parameter int SHIFT = 27
);
  logic                   in_valid;
  logic                   in_ready;
  logic [2*M0LEN-1:0]     in_dividend;
  logic [M0LEN-1:0]       in_m0;
  logic [SHIFT-1:0]       in_m0_inverse;
  logic                   in_last;
  logic [2*M0LEN-1:0]     br_dividend;
  logic [M0LEN-1:0]       br_m0;
  logic [SHIFT-1:0]       br_m0_inverse;
  logic [M0LEN-1:0]       br_quotient;
  logic [M0LEN-1:0]       br_remainder;
  logic                   out_valid;
  logic                   out_ready;
  logic [M0LEN-1:0]       out_quotient;
  logic [M0LEN-1:0]       out_remainder;
  logic                   out_last;

  modport slave (
    input  in_valid, in_dividend, in_m0, in_m0_inverse, in_last,
    input  br_quotient, br_remainder, out_ready,
    output in_ready, br_dividend, br_m0, br_m0_inverse,
    output out_valid, out_quotient, out_remainder, out_last
  );

  modport master (
    output in_valid, in_dividend, in_m0, in_m0_inverse, in_last,
    output br_quotient, br_remainder, out_ready,
    input  in_ready, br_dividend, br_m0, br_m0_inverse,
    input  out_valid, out_quotient, out_remainder, out_last
  );
endinterface

// File: rtl/barrett_issue_ctrl.sv
// Issue/collect stage around the fixed-latency barrett divider: credit-gated
// issue, in-flight tracking and a small circular result FIFO.
module barrett_issue_ctrl_chk #(
  parameter int CW    = 4,
  parameter int DEPTH = 4
) (
  input logic          clk,
  input logic          rst_n,
  input logic [CW-1:0] count,
  input logic          push
);
  // FIFO occupancy never exceeds its capacity
  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count <= CW'(DEPTH));

  // credit scheme must never let a result arrive at a full FIFO
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count == CW'(DEPTH))));
endmodule

module barrett_issue_ctrl #(
  parameter int M0LEN = 14,
  parameter int SHIFT = 27,
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           rst_n,
  barrett_issue_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + LAT + 1) + 1;

  logic               rst_n_q_r;
  logic [LAT-1:0]     vsr_r;
  logic [LAT-1:0]     tsr_r;
  logic [LAT-1:0]     vsr_next_s;
  logic [LAT-1:0]     tsr_next_s;
  logic [PW-1:0]      wr_ptr_r;
  logic [PW-1:0]      rd_ptr_r;
  logic [CW-1:0]      count_r;
  logic [CW-1:0]      inflight_s;
  logic               issue_s;
  logic               push_s;
  logic               pop_s;
  logic               ready_s;
  logic [M0LEN-1:0]   q_mem_r [DEPTH];
  logic [M0LEN-1:0]   r_mem_r [DEPTH];
  logic               l_mem_r [DEPTH];

  function automatic logic [CW-1:0] popcount(input logic [LAT-1:0] v);
    logic [CW-1:0] n;
    n = {CW{1'b0}};
    for (int i = 0; i < LAT; i++) begin
      n = n + CW'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  // barrett registers its own inputs, so the issue buses are plain copies
  assign bus.br_dividend   = bus.in_dividend;
  assign bus.br_m0         = bus.in_m0;
  assign bus.br_m0_inverse = bus.in_m0_inverse;

  // pops in the current cycle are deliberately not credited
  assign inflight_s = popcount(vsr_r);
  assign ready_s    = rst_n_q_r & ((count_r + inflight_s) < CW'(DEPTH));
  assign issue_s    = bus.in_valid & ready_s;
  assign push_s     = vsr_r[LAT-1];
  assign pop_s      = bus.out_valid & bus.out_ready;

  assign bus.in_ready      = ready_s;
  assign bus.out_valid     = (count_r != {CW{1'b0}});
  assign bus.out_quotient  = q_mem_r[rd_ptr_r];
  assign bus.out_remainder = r_mem_r[rd_ptr_r];
  assign bus.out_last      = l_mem_r[rd_ptr_r];

  // next value of the in-flight valid/tag shift registers
  always_comb begin
    vsr_next_s    = {LAT{1'b0}};
    tsr_next_s    = {LAT{1'b0}};
    vsr_next_s[0] = issue_s;
    tsr_next_s[0] = bus.in_last;
    for (int i = 1; i < LAT; i++) begin
      vsr_next_s[i] = vsr_r[i-1];
      tsr_next_s[i] = tsr_r[i-1];
    end
  end

  // control state: reset tracker, in-flight tracking, FIFO pointers and count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rst_n_q_r <= 1'b0;
      vsr_r     <= {LAT{1'b0}};
      tsr_r     <= {LAT{1'b0}};
      wr_ptr_r  <= {PW{1'b0}};
      rd_ptr_r  <= {PW{1'b0}};
      count_r   <= {CW{1'b0}};
    end else begin
      rst_n_q_r <= 1'b1;
      vsr_r     <= vsr_next_s;
      tsr_r     <= tsr_next_s;
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // result capture into the FIFO storage; contents are don't-care under reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      q_mem_r[wr_ptr_r] <= bus.br_quotient;
      r_mem_r[wr_ptr_r] <= bus.br_remainder;
      l_mem_r[wr_ptr_r] <= tsr_r[LAT-1];
    end
  end

  barrett_issue_ctrl_chk #(
    .CW    (CW),
    .DEPTH (DEPTH)
  ) u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .count (count_r),
    .push  (push_s)
  );
endmodule

// File: tb/tb_barrett_issue_ctrl.sv
// Directed bench for barrett_issue_ctrl with a behavioural barrett divider and
// a job-level scoreboard model of occupancy, credit and result order.
module tb_barrett_issue_ctrl;
  localparam int M0LEN = 14;
  localparam int SHIFT = 27;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  typedef struct {
    int unsigned q;
    int unsigned r;
    bit          last;
    int          cyc;
  } job_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   rstq_m = 1'b0;
  job_t sb[$];
  job_t log_q[$];
  int unsigned dq[$];
  bit   lq[$];

  logic [2*M0LEN-1:0] d1, d2;
  logic [M0LEN-1:0]   m1, m2;

  always #5 clk = ~clk;

  barrett_issue_if #(.M0LEN(M0LEN), .SHIFT(SHIFT)) bus ();

  barrett_issue_ctrl #(
    .M0LEN (M0LEN), .SHIFT (SHIFT), .LAT (LAT), .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural two-cycle barrett: exact floor division of the registered operands
  always @(posedge clk) begin
    d1 <= bus.br_dividend;
    m1 <= bus.br_m0;
    d2 <= d1;
    m2 <= m1;
  end
  assign bus.br_quotient  = (m2 != 0) ? M0LEN'(d2 / m2) : '0;
  assign bus.br_remainder = (m2 != 0) ? M0LEN'(d2 % m2) : '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Job-level model: a job is in flight for LAT cycles after issue, then sits
  // in the FIFO until popped; credit is free space over both.
  always @(negedge clk) begin
    int occ;
    int infl;
    bit ev;
    bit er;
    job_t j;
    occ = 0;
    infl = 0;
    foreach (sb[i]) begin
      if (sb[i].cyc + LAT < cyc) occ++;
      else infl++;
    end
    ev = (occ > 0);
    er = rstq_m && (occ + infl < DEPTH);
    if (cyc >= 1) begin
      chk("out_valid", 32'(bus.out_valid), 32'(ev));
      chk("in_ready", 32'(bus.in_ready), 32'(er));
      chk("br_dividend", 32'(bus.br_dividend), 32'(bus.in_dividend));
      chk("br_m0", 32'(bus.br_m0), 32'(bus.in_m0));
      chk("br_m0_inverse", 32'(bus.br_m0_inverse), 32'(bus.in_m0_inverse));
      if (ev) begin
        chk("out_quotient", 32'(bus.out_quotient), sb[0].q);
        chk("out_remainder", 32'(bus.out_remainder), sb[0].r);
        chk("out_last", 32'(bus.out_last), 32'(sb[0].last));
      end
    end
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (ev && bus.out_ready) begin
        log_q.push_back(sb[0]);
        void'(sb.pop_front());
      end
      if (bus.in_valid && bus.in_ready) begin
        j.q    = bus.in_dividend / bus.in_m0;
        j.r    = bus.in_dividend % bus.in_m0;
        j.last = bus.in_last;
        j.cyc  = cyc;
        sb.push_back(j);
      end
    end
    rstq_m = rst_n;
  end

  task automatic stream(input int max_cyc);
    for (int n = 0; n < max_cyc; n++) begin
      @(posedge clk); #1;
      if (dq.size() > 0) begin
        bus.in_valid    = 1'b1;
        bus.in_dividend = dq[0];
        bus.in_last     = lq[0];
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        void'(dq.pop_front());
        void'(lq.pop_front());
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    for (int n = 0; n < max_cyc && sb.size() > 0; n++) begin
      @(posedge clk); #1;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned bq[4];
    int unsigned br[4];
    bq = '{32'd0, 32'd0, 32'd1, 32'd4591};
    br = '{32'd0, 32'd4590, 32'd0, 32'd0};
    bus.in_valid      = 1'b0;
    bus.in_dividend   = '0;
    bus.in_m0         = 14'd4591;
    bus.in_m0_inverse = 27'd29234;
    bus.in_last       = 1'b0;
    bus.out_ready     = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // single job
    log_q.delete();
    bus.in_valid = 1'b1; bus.in_dividend = 28'd1000000; bus.in_last = 1'b1;
    chk("single_ready", 32'(bus.in_ready), 32'd1);
    step(); bus.in_valid = 1'b0;
    step();
    step();
    chk("single_valid_t3", 32'(bus.out_valid), 32'd1);
    chk("single_q", 32'(bus.out_quotient), 32'd217);
    chk("single_r", 32'(bus.out_remainder), 32'd3753);
    chk("single_last", 32'(bus.out_last), 32'd1);
    step();
    chk("single_valid_t4", 32'(bus.out_valid), 32'd0);

    // boundary dividends, back to back
    log_q.delete();
    dq = '{0, 4590, 4591, 21077281};
    lq = '{0, 0, 0, 1};
    stream(4);
    chk("bnd_all_issued", 32'(dq.size()), 32'd0);
    drain(10);
    chk("bnd_count", 32'(log_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      chk("bnd_q", log_q[i].q, bq[i]);
      chk("bnd_r", log_q[i].r, br[i]);
      chk("bnd_spacing", 32'(log_q[i].cyc - log_q[0].cyc), 32'(i));
    end

    // backpressure: FIFO fills, credit closes, then drains in order
    log_q.delete();
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      dq.push_back(4592 * k);
      lq.push_back(k[0]);
    end
    stream(8);
    chk("bp_issued", 32'(6 - dq.size()), 32'd4);
    chk("bp_ready_low", 32'(bus.in_ready), 32'd0);
    chk("bp_fifo_full_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_nothing_popped", 32'(log_q.size()), 32'd0);
    bus.out_ready = 1'b1;
    stream(12);
    drain(10);
    chk("bp_count", 32'(log_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < log_q.size(); i++) begin
      chk("bp_q", log_q[i].q, 32'(i + 1));
      chk("bp_r", log_q[i].r, 32'(i + 1));
    end

    // simultaneous push/pop through pointer wrap
    log_q.delete();
    for (int i = 0; i < 10; i++) begin
      dq.push_back(4591 * (i + 3) + i);
      lq.push_back(1'b0);
    end
    stream(12);
    drain(10);
    chk("pp_count", 32'(log_q.size()), 32'd10);
    for (int i = 0; i < 10 && i < log_q.size(); i++) begin
      chk("pp_q", log_q[i].q, 32'(i + 3));
      chk("pp_r", log_q[i].r, 32'(i));
    end

    // tag passthrough
    log_q.delete();
    for (int i = 0; i < 8; i++) begin
      dq.push_back(100 + i);
      lq.push_back(i[0]);
    end
    stream(10);
    drain(10);
    chk("tag_count", 32'(log_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      chk("tag_last", 32'(log_q[i].last), 32'(i % 2));
    end

    // reset in the middle of operation
    log_q.delete();
    bus.in_valid = 1'b1; bus.in_dividend = 28'd4592; bus.in_last = 1'b0;
    step(); bus.in_dividend = 28'd9184;
    step(); bus.in_dividend = 28'd13776; rst_n = 1'b0;
    step(); rst_n = 1'b1; bus.in_valid = 1'b0;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    chk("rst_ready_back", 32'(bus.in_ready), 32'd1);
    repeat (6) step();
    chk("rst_no_stale", 32'(log_q.size()), 32'd0);
    bus.in_valid = 1'b1; bus.in_dividend = 28'd9182; bus.in_last = 1'b1;
    step(); bus.in_valid = 1'b0;
    drain(10);
    step();
    chk("rst_fresh_count", 32'(log_q.size()), 32'd1);
    if (log_q.size() > 0) begin
      chk("rst_fresh_q", log_q[0].q, 32'd2);
      chk("rst_fresh_r", log_q[0].r, 32'd0);
    end

    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
